// File: rtl/mul_div_pkg.sv
// Shared encodings and constants for the multi-cycle multiply/divide unit.
package mul_div_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_e;

    localparam logic [WIDTH_DEFAULT-1:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

endpackage

// File: rtl/mul_div_divcore.sv
// One restoring-division step: shift in the next dividend bit, trial subtract.
module mul_div_divcore #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem < divisor always holds, so the shifted value fits and diff[WIDTH] is the borrow
    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign diff    = shifted - {1'b0, div_i};
    assign rem_o   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_o   = {quo_i[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/mul_div_unit.sv
// Signed 32-iteration Booth multiply / restoring divide unit feeding ZHigh/ZLow.
// Divide path is compiled in only when MUL_DIV_UNIT_DIV_EN is defined.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z_hi,
    output logic [WIDTH-1:0] z_lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    op_e              op_q, op_d;
    logic [WIDTH:0]   acc_a_q, acc_a_d;
    logic [WIDTH-1:0] acc_q_q, acc_q_d;
    logic             qm1_q, qm1_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] z_hi_q, z_hi_d;
    logic [WIDTH-1:0] z_lo_q, z_lo_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   booth_a;
    logic [WIDTH-1:0] booth_q;

    // A is one bit wider than the operands so -(-2^31) cannot overflow
    assign m_ext = {m_q[WIDTH-1], m_q};

    always_comb begin
        booth_sum = acc_a_q;
        unique case ({acc_q_q[0], qm1_q})
            2'b01:   booth_sum = acc_a_q + m_ext;
            2'b10:   booth_sum = acc_a_q - m_ext;
            default: booth_sum = acc_a_q;
        endcase
    end

    assign booth_a = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    assign booth_q = {booth_sum[0], acc_q_q[WIDTH-1:1]};

`ifdef MUL_DIV_UNIT_DIV_EN
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_quo;

    function automatic logic [WIDTH-1:0] cneg(
        input logic [WIDTH-1:0] v,
        input logic             n
    );
        return n ? (~v + 1'b1) : v;
    endfunction

    mul_div_divcore #(
        .WIDTH (WIDTH)
    ) u_divcore (
        .rem_i (acc_a_q[WIDTH-1:0]),
        .quo_i (acc_q_q),
        .div_i (m_q),
        .rem_o (div_rem),
        .quo_o (div_quo)
    );
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_a_d = acc_a_q;
        acc_q_d = acc_q_q;
        qm1_d   = qm1_q;
        m_d     = m_q;
        z_hi_d  = z_hi_q;
        z_lo_d  = z_lo_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
`ifdef MUL_DIV_UNIT_DIV_EN
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    op_d    = op_e'(op);
                    acc_a_d = '0;
                    qm1_d   = 1'b0;
                    m_d     = operand_a;
                    acc_q_d = operand_b;
`ifdef MUL_DIV_UNIT_DIV_EN
                    neg_q_d = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                    neg_r_d = operand_a[WIDTH-1];
                    if (op_e'(op) == OP_DIV) begin
                        m_d     = cneg(operand_b, operand_b[WIDTH-1]);
                        acc_q_d = cneg(operand_a, operand_a[WIDTH-1]);
                    end
`endif
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q == OP_MUL) begin
                    acc_a_d = booth_a;
                    acc_q_d = booth_q;
                    qm1_d   = acc_q_q[0];
                end else begin
`ifdef MUL_DIV_UNIT_DIV_EN
                    acc_a_d = {1'b0, div_rem};
                    acc_q_d = div_quo;
`endif
                end
                if (cnt_q == LAST) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
                done_d  = 1'b1;
                z_hi_d  = '0;
                z_lo_d  = '0;
                dbz_d   = 1'b0;
                if (op_q == OP_MUL) begin
                    z_hi_d = acc_a_q[WIDTH-1:0];
                    z_lo_d = acc_q_q;
                end else begin
`ifdef MUL_DIV_UNIT_DIV_EN
                    // divisor 0 leaves |dividend| in the remainder after 32 steps
                    z_hi_d = cneg(acc_a_q[WIDTH-1:0], neg_r_q);
                    if (m_q == '0) begin
                        z_lo_d = DBZ_QUOTIENT[WIDTH-1:0];
                        dbz_d  = 1'b1;
                    end else begin
                        z_lo_d = cneg(acc_q_q, neg_q_q);
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MUL;
            acc_a_q <= '0;
            acc_q_q <= '0;
            qm1_q   <= 1'b0;
            m_q     <= '0;
            z_hi_q  <= '0;
            z_lo_q  <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_a_q <= acc_a_d;
            acc_q_q <= acc_q_d;
            qm1_q   <= qm1_d;
            m_q     <= m_d;
            z_hi_q  <= z_hi_d;
            z_lo_q  <= z_lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
`ifdef MUL_DIV_UNIT_DIV_EN
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
`endif
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = done_q;
    assign z_hi        = z_hi_q;
    assign z_lo        = z_lo_q;
    assign div_by_zero = dbz_q;

endmodule
